// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and datapath constants.
package mul_div_pkg;

  localparam int WIDTH    = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 5;

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(ITER_CNT - 1);

  localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mul_div_signfix.sv
// Operand magnitude extraction and final result sign fix-up.
// Purely combinational; shared by multiply and divide paths.
module mul_div_signfix
  import mul_div_pkg::*;
(
  input  logic             sgn,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             neg_a,
  output logic             neg_b,
  output logic [WIDTH-1:0] abs_a,
  output logic [WIDTH-1:0] abs_b,
  input  logic             is_div,
  input  logic             sa,
  input  logic             sb,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] prod;

  // magnitudes of the incoming operands for signed ops
  always_comb begin
    neg_a = sgn & rs[WIDTH-1];
    neg_b = sgn & rt[WIDTH-1];
    abs_a = neg_a ? -rs : rs;
    abs_b = neg_b ? -rt : rt;
  end

  // product negates as a whole; remainder follows dividend
  always_comb begin
    prod   = {raw_hi, raw_lo};
    res_hi = raw_hi;
    res_lo = raw_lo;
    if (is_div) begin
      if (sa ^ sb) res_lo = -raw_lo;
      if (sa)      res_hi = -raw_hi;
    end else if (sa ^ sb) begin
      {res_hi, res_lo} = -prod;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO.
// Divider is built only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
  import mul_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lsh;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] lsh_n;
  logic [WIDTH:0]   sum;

  logic             in_sgn;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] res_lo;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic             div0;
  logic [WIDTH:0]   shf;
  logic [WIDTH+1:0] diff;
`endif

  assign in_sgn = (op == OP_MULT) || (op == OP_DIV);

  mul_div_signfix u_signfix (
    .sgn    (in_sgn),
    .rs     (rs_data),
    .rt     (rt_data),
    .neg_a  (neg_a),
    .neg_b  (neg_b),
    .abs_a  (abs_a),
    .abs_b  (abs_b),
    .is_div (is_div),
    .sa     (sa),
    .sb     (sb),
    .raw_hi (acc),
    .raw_lo (lsh),
    .res_hi (fix_hi),
    .res_lo (fix_lo)
  );

  // one radix-2 step: shift-add or restoring shift-subtract
  always_comb begin
    sum   = {1'b0, acc} + (lsh[0] ? {1'b0, opnd} : '0);
    acc_n = sum[WIDTH:1];
    lsh_n = {sum[0], lsh[WIDTH-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
    shf  = {acc, lsh[WIDTH-1]};
    diff = {1'b0, shf} - {2'b0, opnd};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        acc_n = diff[WIDTH-1:0];
        lsh_n = {lsh[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shf[WIDTH-1:0];
        lsh_n = {lsh[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // divide by zero forces an all-ones quotient
  always_comb begin
    res_lo = fix_lo;
`ifdef MUL_DIV_UNIT_DIV_EN
    if (is_div && div0) res_lo = DIV0_LO;
`endif
  end

  // control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      lsh    <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
      div0   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (hi_we) hi <= mt_data;
          if (lo_we) lo <= mt_data;
          if (start) begin
            is_div <= op[1];
            sa     <= neg_a;
            sb     <= op[1] ? neg_a : neg_b;
            opnd   <= op[1] ? abs_b : abs_a;
            lsh    <= op[1] ? abs_a : abs_b;
            acc    <= '0;
            cnt    <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
            sb     <= neg_b;
            div0   <= (rt_data == '0);
            state  <= ST_RUN;
            busy   <= 1'b1;
`else
            if (op[1]) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
`endif
          end
        end
        ST_RUN: begin
          acc <= acc_n;
          lsh <= lsh_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= fix_hi;
          lo    <= res_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Divide scenarios follow MUL_DIV_UNIT_DIV_EN.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .mt_data (mt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic mt_write(input bit to_hi,
                          input logic [31:0] d);
    @(negedge clk);
    hi_we   = to_hi;
    lo_we   = !to_hi;
    mt_data = d;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    checks++;
    if ((to_hi ? hi : lo) !== d) begin
      errors++;
      $display("FAIL mt_write got %h want %h",
               to_hi ? hi : lo, d);
    end
  endtask

  task automatic run_op(input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int ecyc,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input string nm);
    logic [31:0] oh;
    logic [31:0] ol;
    int cyc;
    bit bad;
    bit got;
    oh = hi;
    ol = lo;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    rs_data = 32'h5A5A_5A5A;
    rt_data = 32'hA5A5_A5A5;
    cyc = 1;
    got = 0;
    bad = 0;
    while (cyc <= 60 && !got) begin
      if (done === 1'b1) got = 1;
      else begin
        if (busy !== 1'b1 || hi !== oh || lo !== ol)
          bad = 1;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s busy/hold got bad want ok", nm);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout got none want %0d",
               nm, ecyc);
    end else if (cyc != ecyc) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d",
               nm, cyc, ecyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done got %b want 0",
               nm, busy);
    end
    checks++;
    if (hi !== eh) begin
      errors++;
      $display("FAIL %s hi got %h want %h", nm, hi, eh);
    end
    checks++;
    if (lo !== el) begin
      errors++;
      $display("FAIL %s lo got %h want %h", nm, lo, el);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (hi !== 32'h0) begin
      errors++;
      $display("FAIL reset_hi got %h want 0", hi);
    end
    checks++;
    if (lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_lo got %h want 0", lo);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", done);
    end
    rst = 1'b0;
  endtask

  task automatic test_mult;
    mt_write(1'b1, 32'h0000_AAAA);
    mt_write(1'b0, 32'h0000_5555);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
           32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg7x3");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 34,
           32'h4000_0000, 32'h0, "mult_minxmin");
    run_op(2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 34,
           32'hFFFF_FFFF, 32'h8000_0001, "mult_maxxm1");
  endtask

`ifdef MUL_DIV_UNIT_DIV_EN
  task automatic test_div;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 34,
           32'h1, 32'hFFFF_FFFD, "div_7byneg2");
    run_op(2'b11, 32'd100, 32'd0, 34,
           32'd100, 32'hFFFF_FFFF, "divu_by0");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 34,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34,
           32'h0, 32'h8000_0000, "div_ovf");
    run_op(2'b11, 32'hFFFF_FFFF, 32'd10, 34,
           32'd5, 32'h1999_9999, "divu_max");
  endtask
`else
  task automatic test_nodiv;
    mt_write(1'b1, 32'h0000_0BAD);
    mt_write(1'b0, 32'h0000_0F00);
    run_op(2'b11, 32'd9, 32'd3, 1,
           32'h0000_0BAD, 32'h0000_0F00, "nodiv_divu");
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL nodiv_pulse got %b want 0", done);
    end
  endtask
`endif

  task automatic test_ignore;
    logic [31:0] oh;
    logic [31:0] el;
    logic [31:0] eh;
    logic [1:0]  o;
    int cyc;
    bit got;
    bit bad;
`ifdef MUL_DIV_UNIT_DIV_EN
    o  = 2'b11;
    el = 32'd3;
    eh = 32'd1;
`else
    o  = 2'b01;
    el = 32'd30;
    eh = 32'd0;
`endif
    oh = hi;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = 32'd10;
    rt_data = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    got = 0;
    bad = 0;
    while (cyc <= 60 && !got) begin
      if (done === 1'b1) got = 1;
      else begin
        if (cyc == 10) begin
          start   = 1'b1;
          op      = 2'b01;
          rs_data = 32'd7;
          rt_data = 32'd7;
          hi_we   = 1'b1;
          mt_data = 32'hDEAD_BEEF;
        end else begin
          start = 1'b0;
          hi_we = 1'b0;
        end
        if (hi !== oh) bad = 1;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    start = 1'b0;
    hi_we = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ignore_mt hi changed want %h", oh);
    end
    checks++;
    if (!got || cyc != 34) begin
      errors++;
      $display("FAIL ignore_lat got %0d want 34", cyc);
    end
    checks++;
    if (lo !== el || hi !== eh) begin
      errors++;
      $display("FAIL ignore_res got %h/%h want %h/%h",
               hi, lo, eh, el);
    end
  endtask

  task automatic test_rst_abort;
    bit seen;
    mt_write(1'b1, 32'h11);
    mt_write(1'b0, 32'h22);
    @(negedge clk);
    start   = 1'b1;
    op      = 2'b01;
    rs_data = 32'd5;
    rt_data = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL abort_hilo got %h/%h want 0/0",
               hi, lo);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b want 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done !== 1'b0) seen = 1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_done got pulse want none");
    end
    mt_write(1'b0, 32'h0000_1234);
  endtask

  task automatic test_back_to_back;
    run_op(2'b01, 32'd4, 32'd4, 34,
           32'h0, 32'd16, "b2b_first");
    run_op(2'b01, 32'd2, 32'd3, 34,
           32'h0, 32'd6, "b2b_second");
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = 32'h0;
    rt_data = 32'h0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    mt_data = 32'h0;
    test_reset();
    test_mult();
`ifdef MUL_DIV_UNIT_DIV_EN
    test_div();
`else
    test_nodiv();
`endif
    test_ignore();
    test_rst_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
